// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared helpers for the counter block
//
// Purpose: width helper used to size the count register.
//   clog2_min1(n) : returns max(1, $clog2(n)), so a modulus of 1 still
//                   gets a one-bit count register.

package counter_pkg;

   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - modulo-M up counter with enable and carry-out
//
// Purpose: counts 0..M-1 on enabled clock edges and wraps to 0.
//   The carry-out flags the enabled cycle on which the wrap happens.
//
// Parameters:
//   M   : counting modulus, integer >= 1 (default 10)
//
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset, has priority over en
//   en  : count enable
//   cnt : current count, registered, CW = max(1, $clog2(M)) bits
//   co  : carry-out, combinational, en AND (cnt == M-1)
//
// Build option:
//   COUNTER_ASSERT_EN : when defined, compiles in simulation assertions
//                       (range, co implies en, reset clears cnt, M >= 1).

module counter
   import counter_pkg::*;
#(
   parameter int M = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   output logic [clog2_min1(M)-1:0] cnt,
   output logic                     co
);

   localparam int CW = clog2_min1(M);
   localparam logic [CW-1:0] LAST = CW'(M - 1);

   // Wrapping at LAST keeps codes M..2^CW-1 unreachable. For M=1, LAST
   // is 0, so every enabled edge "wraps" and cnt stays at 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign co = en & (cnt == LAST);

`ifdef COUNTER_ASSERT_EN
   generate
      if (M < 1) begin : g_bad_modulus
         $error("counter: modulus M must be >= 1");
      end
   endgenerate

   // Simulation-only flag: cnt has no defined value until the first reset.
   logic r_seen_rst;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seen_rst <= 1'b1;
      end
   end

   a_range : assert property (@(posedge clk) disable iff (rst)
      (r_seen_rst === 1'b1) |-> (int'(cnt) < M));
   a_co_en : assert property (@(posedge clk)
      co |-> en);
   a_rst_clr : assert property (@(posedge clk)
      rst |=> (cnt == '0));
`endif

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - self-checking scoreboard bench for counter

module tb_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] rst_v;
   logic [3:0] en_v;
   logic [3:0] co_v;
   logic [3:0] cnt_m10;
   logic [3:0] cnt_m16;
   logic [2:0] cnt_m8;
   logic [0:0] cnt_m1;

   counter #(.M(10)) u_m10 (.clk(clk), .rst(rst_v[0]), .en(en_v[0]), .cnt(cnt_m10), .co(co_v[0]));
   counter #(.M(16)) u_m16 (.clk(clk), .rst(rst_v[1]), .en(en_v[1]), .cnt(cnt_m16), .co(co_v[1]));
   counter #(.M(8))  u_m8  (.clk(clk), .rst(rst_v[2]), .en(en_v[2]), .cnt(cnt_m8),  .co(co_v[2]));
   counter #(.M(1))  u_m1  (.clk(clk), .rst(rst_v[3]), .en(en_v[3]), .cnt(cnt_m1),  .co(co_v[3]));

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int m_cnt[4];
   int mod_v[4];
   int co_hits;

   function automatic int get_cnt(input int d);
      case (d)
         0:       return int'(cnt_m10);
         1:       return int'(cnt_m16);
         2:       return int'(cnt_m8);
         default: return int'(cnt_m1);
      endcase
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One clock cycle on DUT d: drive inputs, check combinational co for the
   // current cycle, then check the registered count after the edge.
   task automatic step(input int d, input bit r, input bit e);
      int got;
      @(negedge clk);
      rst_v[d] = r;
      en_v[d]  = e;
      #1;
      exp_q.push_back((e && m_cnt[d] == mod_v[d] - 1) ? 1 : 0);
      got = int'(co_v[d]);
      co_hits += got;
      chk($sformatf("co_m%0d", mod_v[d]), got, exp_q.pop_front());
      if (r) begin
         m_cnt[d] = 0;
      end else if (e) begin
         m_cnt[d] = (m_cnt[d] == mod_v[d] - 1) ? 0 : m_cnt[d] + 1;
      end
      exp_q.push_back(m_cnt[d]);
      @(posedge clk);
      #1;
      got = get_cnt(d);
      chk($sformatf("cnt_m%0d", mod_v[d]), got, exp_q.pop_front());
      chk($sformatf("range_m%0d", mod_v[d]), (got < mod_v[d]) ? 1 : 0, 1);
   endtask

   task automatic idle(input int d);
      @(negedge clk);
      en_v[d]  = 1'b0;
      rst_v[d] = 1'b0;
   endtask

   initial begin
      mod_v[0] = 10;
      mod_v[1] = 16;
      mod_v[2] = 8;
      mod_v[3] = 1;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      rst_v = 4'hF;
      en_v  = 4'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_m10", get_cnt(0), 0);
      chk("reset_m16", get_cnt(1), 0);
      chk("reset_m8",  get_cnt(2), 0);
      chk("reset_m1",  get_cnt(3), 0);
      chk("reset_co",  int'(co_v), 0);
      @(negedge clk);
      rst_v = 4'h0;

      // M=10: two reset cycles then 25 enabled cycles
      step(0, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0);
      co_hits = 0;
      for (int i = 0; i < 25; i++) step(0, 1'b0, 1'b1);
      chk("m10_co_hits", co_hits, 2);
      chk("m10_end", get_cnt(0), 5);
      idle(0);

      // M=10: alternating enable, pause without losing position
      step(0, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) step(0, 1'b0, (i % 2) == 0);
      for (int i = 0; i < 30; i++) step(0, 1'b0, 1'($urandom_range(0, 1)));
      idle(0);

      // M=16: full wrap period
      step(1, 1'b1, 1'b0);
      co_hits = 0;
      for (int i = 0; i < 40; i++) step(1, 1'b0, 1'b1);
      chk("m16_co_hits", co_hits, 2);
      chk("m16_end", get_cnt(1), 8);
      for (int i = 0; i < 30; i++) step(1, 1'b0, 1'($urandom_range(0, 1)));
      idle(1);

      // M=8: reset mid-count with en high, reset wins
      step(2, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(2, 1'b0, 1'b1);
      chk("m8_at5", get_cnt(2), 5);
      step(2, 1'b1, 1'b1);
      chk("m8_rst_wins", get_cnt(2), 0);
      co_hits = 0;
      for (int i = 0; i < 7; i++) step(2, 1'b0, 1'b1);
      chk("m8_no_early_co", co_hits, 0);
      step(2, 1'b0, 1'b1);
      chk("m8_co_8th", co_hits, 1);
      chk("m8_wrapped", get_cnt(2), 0);
      idle(2);

      // M=1: cnt fixed at 0, co mirrors en
      step(3, 1'b1, 1'b1);
      co_hits = 0;
      for (int i = 0; i < 20; i++) step(3, 1'b0, (i % 3) != 0);
      chk("m1_co_hits", co_hits, 13);
      for (int i = 0; i < 10; i++) step(3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle(3);

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
